opram_loader: RTL and testbench
===============================

OPRAM_LOADER -- requirements
Module: opram_loader

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 1_000_000, maximum idle cycles between accepted bytes during a load; 0 disables the timeout.
REQ-002 SHALL have port: clk  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  in  1  begin-load pulse.
REQ-005 SHALL have port: in_valid  in  1  source has a byte on in_data.
REQ-006 SHALL have port: in_data  in  8  byte stream: length, opcodes, optional checksum.
REQ-007 SHALL have port: in_ready  out  1  loader accepts a byte this cycle.
REQ-008 SHALL have port: write  out  1  opcode-RAM write strobe.
REQ-009 SHALL have port: writeaddr  out  8  opcode-RAM write address.
REQ-010 SHALL have port: writeop  out  8  opcode-RAM write data.
REQ-011 SHALL have port: write_rst  out  1  opcode-RAM clear strobe.
REQ-012 SHALL have port: cpu_rst  out  1  holds the CPU core in reset.
REQ-013 SHALL have port: busy, done, error  out  1 each  status flags.

Function
REQ-014 SHALL have states IDLE, CLEAR, LEN, DATA, CSUM, DONE, ERROR.
REQ-015 SHALL accept a byte only on a cycle with in_valid and in_ready both high.
REQ-016 SHALL hold in_ready high only in LEN, DATA and CSUM.
REQ-017 SHALL go from IDLE, DONE or ERROR to CLEAR when start is high; start SHALL be ignored in all other states.
REQ-018 SHALL stay in CLEAR for exactly one cycle, pulsing write_rst, then go to LEN.
REQ-019 SHALL latch the byte accepted in LEN as count N (0-255).
REQ-020 SHALL go from LEN to DATA if N>0; if N=0, SHALL go to CSUM when checksum is enabled, else to DONE.
REQ-021 SHALL, for the k-th accepted DATA byte (k=0..N-1), drive write=1, writeaddr=k and writeop=byte on the next cycle only.
REQ-022 SHALL leave DATA after byte N-1 is accepted, to CSUM or DONE per REQ-020.
REQ-023 SHALL hold write=0 on every other cycle and SHALL never advance writeaddr past N-1.
REQ-024 SHALL hold cpu_rst high in CLEAR, LEN, DATA, CSUM and ERROR, and low in IDLE and DONE.
REQ-025 SHALL hold busy high in CLEAR, LEN, DATA and CSUM; done high only in DONE; error high only in ERROR.
REQ-026 SHALL, when TIMEOUT_CYCLES>0, go to ERROR if TIMEOUT_CYCLES consecutive cycles pass in LEN, DATA or CSUM with no byte accepted.
REQ-027 SHALL reset the idle counter on every accepted byte and on entry to CLEAR.
REQ-028 SHALL, when a byte is accepted on the same cycle the timeout would expire, treat the byte as accepted with no timeout.

Reset
REQ-029 SHALL, on rst assertion at any time including mid-load, go to IDLE immediately.
REQ-030 SHALL, on reset, drive in_ready, write, write_rst, cpu_rst, busy, done and error to 0, writeaddr and writeop to 0x00, and clear all counters and the checksum accumulator.

Configuration
REQ-031 SHALL, with LOADER_CHECKSUM_EN defined, keep an 8-bit sum mod 256 of all DATA bytes and accept one byte in CSUM.
REQ-032 SHALL, with LOADER_CHECKSUM_EN defined, go to DONE if the CSUM byte equals the sum and to ERROR otherwise.
REQ-033 SHALL, without LOADER_CHECKSUM_EN, contain no CSUM state, accumulator or checksum logic.

Structure
REQ-034 SHALL place the state encoding, the 8-bit data/address width constant and the default TIMEOUT_CYCLES in shared package gcore_loader_pkg.
REQ-035 SHALL implement the timeout counter as sub-module loader_timer, with inputs clear and enable and output expired.

Verification
REQ-036 SHALL test: start, bytes 03,A1,B2,C3 with no gaps -> write_rst pulse, writes (00,A1),(01,B2),(02,C3), then done=1 and cpu_rst=0.
REQ-037 SHALL test, with LOADER_CHECKSUM_EN: 02,10,20,30 -> DONE; 02,10,20,31 -> ERROR, cpu_rst stays 1, no further writes.
REQ-038 SHALL test: length byte 00 -> no write pulses; DONE, or CSUM when checksum is enabled.
REQ-039 SHALL test, with TIMEOUT_CYCLES=8: stall in_valid low for 8 cycles after 2 of 4 DATA bytes -> ERROR; a new start then re-enters CLEAR.
REQ-040 SHALL test: rst asserted mid-DATA, then a second start during busy -> outputs as in REQ-030; the start during busy is ignored.
REQ-041 SHALL test: in_valid toggled randomly with N=255 -> exactly 255 write pulses at addresses 00..FE in order.

Source files
------------

// File: rtl/gcore_loader_pkg.sv
// Shared constants for the opcode-RAM loader: state encoding, data width, default timeout.
// Optional feature macro: LOADER_CHECKSUM_EN adds the CSUM state.
package gcore_loader_pkg;

  localparam int unsigned DataW                = 8;
  localparam int unsigned DefaultTimeoutCycles = 1_000_000;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StClear = 3'd1;
  localparam state_t StLen   = 3'd2;
  localparam state_t StData  = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t StCsum  = 3'd4;
`endif
  localparam state_t StDone  = 3'd5;
  localparam state_t StError = 3'd6;

  // States in which the loader is willing to take a byte from the source.
  function automatic logic is_load_state(input state_t s);
`ifdef LOADER_CHECKSUM_EN
    return (s == StLen) || (s == StData) || (s == StCsum);
`else
    return (s == StLen) || (s == StData);
`endif
  endfunction

endpackage

// File: rtl/loader_timer.sv
// Idle-cycle watchdog: expired fires on the TIMEOUT_CYCLES-th consecutive enabled cycle.
// TIMEOUT_CYCLES = 0 removes the counter and expired stays low.
module loader_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic w_unused_inputs;
    assign w_unused_inputs = ^{clk, rst, clear, enable};
    assign expired         = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] r_cnt;

    assign expired = enable & (r_cnt == LastCnt);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (clear || expired) begin
        r_cnt <= '0;
      end else if (enable) begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/opram_loader.sv
// Streams a length-prefixed opcode image into the opcode RAM while holding the CPU in reset.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing mod-256 checksum byte).
module opram_loader
  import gcore_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [DataW-1:0] in_data,
  output logic             in_ready,
  output logic             write,
  output logic [DataW-1:0] writeaddr,
  output logic [DataW-1:0] writeop,
  output logic             write_rst,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             error
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t StAfterData = StCsum;
`else
  localparam state_t StAfterData = StDone;
`endif

  state_t           r_state;
  state_t           w_state_next;
  logic [DataW-1:0] r_len;
  logic [DataW-1:0] r_idx;
  logic             r_write;
  logic [DataW-1:0] r_waddr;
  logic [DataW-1:0] r_wop;
  logic             w_accept;
  logic             w_last_data;
  logic             w_expired;
  logic             w_tmr_clear;
  logic             w_tmr_enable;

  assign in_ready    = is_load_state(r_state);
  assign w_accept    = in_valid & in_ready;
  assign w_last_data = (r_idx == (r_len - DataW'(1)));

  assign w_tmr_clear  = (r_state == StClear) | w_accept;
  assign w_tmr_enable = in_ready & ~in_valid;

  loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_tmr_clear),
    .enable (w_tmr_enable),
    .expired(w_expired)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [DataW-1:0] r_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
    end else if (r_state == StClear) begin
      r_sum <= '0;
    end else if ((r_state == StData) && w_accept) begin
      r_sum <= r_sum + in_data;
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle, StDone, StError: begin
        if (start) w_state_next = StClear;
      end
      StClear: w_state_next = StLen;
      StLen: begin
        if (w_accept) begin
          w_state_next = (in_data != '0) ? StData : StAfterData;
        end else if (w_expired) begin
          w_state_next = StError;
        end
      end
      StData: begin
        if (w_accept) begin
          if (w_last_data) w_state_next = StAfterData;
        end else if (w_expired) begin
          w_state_next = StError;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCsum: begin
        if (w_accept) begin
          w_state_next = (in_data == r_sum) ? StDone : StError;
        end else if (w_expired) begin
          w_state_next = StError;
        end
      end
`endif
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_len   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_waddr <= '0;
      r_wop   <= '0;
    end else begin
      r_state <= w_state_next;
      r_write <= 1'b0;
      if (r_state == StClear) begin
        r_len <= '0;
        r_idx <= '0;
      end
      if ((r_state == StLen) && w_accept) begin
        r_len <= in_data;
      end
      // Address/data hold their last value between strobes; r_idx stops at N.
      if ((r_state == StData) && w_accept) begin
        r_write <= 1'b1;
        r_waddr <= r_idx;
        r_wop   <= in_data;
        r_idx   <= r_idx + DataW'(1);
      end
    end
  end

  assign write     = r_write;
  assign writeaddr = r_waddr;
  assign writeop   = r_wop;
  assign write_rst = (r_state == StClear);
  assign cpu_rst   = (r_state != StIdle) && (r_state != StDone);
  assign busy      = in_ready | (r_state == StClear);
  assign done      = (r_state == StDone);
  assign error     = (r_state == StError);

endmodule

// File: tb/tb_opram_loader.sv
// Self-checking bench for opram_loader; builds with or without LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_opram_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [15:0] wr_q_t[$];

  localparam int unsigned Timeout = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       write;
  logic [7:0] writeaddr;
  logic [7:0] writeop;
  logic       write_rst;
  logic       cpu_rst;
  logic       busy;
  logic       done;
  logic       error;

  int    checks = 0;
  int    failures = 0;
  wr_q_t obs_q;
  int    clr_pulses = 0;

  always #5 clk = ~clk;

  opram_loader #(
    .TIMEOUT_CYCLES(Timeout)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .write    (write),
    .writeaddr(writeaddr),
    .writeop  (writeop),
    .write_rst(write_rst),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  // Observed RAM traffic, sampled away from the active edge.
  always @(negedge clk) begin
    if (write === 1'b1) obs_q.push_back({writeaddr, writeop});
    if (write_rst === 1'b1) clr_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_write"}, 32'(write), 32'd0);
    check({tag, "_writeaddr"}, 32'(writeaddr), 32'd0);
    check({tag, "_writeop"}, 32'(writeop), 32'd0);
    check({tag, "_write_rst"}, 32'(write_rst), 32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic check_flags(input string tag, input logic exp_done, input logic exp_err);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(exp_err));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_writes(input string tag, input int base, input wr_q_t exp);
    check({tag, "_nwrites"}, 32'(obs_q.size() - base), 32'(exp.size()));
    foreach (exp[i]) begin
      if (base + i < obs_q.size())
        check($sformatf("%s_w%0d", tag, i), 32'(obs_q[base + i]), 32'(exp[i]));
    end
  endtask

  // Reference: byte k of the image lands at address k.
  function automatic wr_q_t expected_writes(input byte_q_t data);
    wr_q_t q;
    foreach (data[k]) q.push_back({8'(k), data[k]});
    return q;
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int unsigned gap);
    int waited = 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("handshake_wait", 32'(in_ready), 32'd1);
    else @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input byte_q_t s, input int unsigned gmin, input int unsigned gmax);
    do_start();
    foreach (s[i]) send(s[i], $urandom_range(gmax, gmin));
  endtask

  // Full, well-formed load followed by checks on traffic and final flags.
  task automatic run_load(input string tag, input byte_q_t data, input int unsigned gmin,
                          input int unsigned gmax);
    byte_q_t stream;
    int base = obs_q.size();
    int p0 = clr_pulses;
    stream.push_back(8'(data.size()));
    foreach (data[k]) stream.push_back(data[k]);
`ifdef LOADER_CHECKSUM_EN
    begin
      int unsigned sum = 0;
      foreach (data[k]) sum += int'(data[k]);
      stream.push_back(8'(sum % 256));
    end
`endif
    send_stream(stream, gmin, gmax);
    repeat (2) @(negedge clk);
    check_writes(tag, base, expected_writes(data));
    check({tag, "_clr_pulses"}, 32'(clr_pulses - p0), 32'd1);
    check_flags(tag, 1'b1, 1'b0);
  endtask

  initial begin
    byte_q_t d;
    int base;
    int p0;

    // Power-on reset.
    repeat (2) @(negedge clk);
    check_idle_outputs("por");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("por_release");

    // Basic three-byte image, back-to-back.
    d = '{8'hA1, 8'hB2, 8'hC3};
    run_load("basic", d, 0, 0);

`ifdef LOADER_CHECKSUM_EN
    // Good and bad checksum.
    base = obs_q.size();
    send_stream('{8'h02, 8'h10, 8'h20, 8'h30}, 0, 0);
    @(negedge clk);
    check_writes("csum_ok", base, '{16'h0010, 16'h0120});
    check_flags("csum_ok", 1'b1, 1'b0);
    base = obs_q.size();
    send_stream('{8'h02, 8'h10, 8'h20, 8'h31}, 0, 0);
    @(negedge clk);
    check_flags("csum_bad", 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check_writes("csum_bad", base, '{16'h0010, 16'h0120});
    check("csum_bad_cpu_rst_hold", 32'(cpu_rst), 32'd1);
`endif

    // Zero-length image.
    base = obs_q.size();
    do_start();
    send(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    check("len0_csum_busy", 32'(busy), 32'd1);
    check("len0_csum_ready", 32'(in_ready), 32'd1);
    check("len0_csum_done", 32'(done), 32'd0);
    send(8'h00, 0);
`endif
    check_flags("len0", 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("len0_nwrites", 32'(obs_q.size() - base), 32'd0);

    // Stall mid-image until the idle timeout fires, then restart.
    base = obs_q.size();
    d = '{8'($urandom), 8'($urandom)};
    do_start();
    send(8'h04, 0);
    send(d[0], 0);
    send(d[1], 0);
    repeat (Timeout - 1) @(negedge clk);
    check("tmo_before_error", 32'(error), 32'd0);
    check("tmo_before_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_flags("tmo", 1'b0, 1'b1);
    check_writes("tmo", base, expected_writes(d));
    p0 = clr_pulses;
    do_start();
    check("tmo_restart_write_rst", 32'(write_rst), 32'd1);
    check("tmo_restart_busy", 32'(busy), 32'd1);
    pulse_reset();

    // A byte arriving on the last allowed idle cycle still counts.
    d = '{8'($urandom), 8'($urandom), 8'($urandom)};
    run_load("tmo_edge", d, Timeout - 1, Timeout - 1);

    // Asynchronous reset mid-DATA, then a start during busy is ignored.
    do_start();
    send(8'h05, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    #2 rst = 1'b1;
    #1 check_idle_outputs("async_rst");
    @(negedge clk);
    check_idle_outputs("rst_held");
    rst = 1'b0;
    @(negedge clk);
    base = obs_q.size();
    p0 = clr_pulses;
    d = '{8'($urandom), 8'($urandom), 8'($urandom)};
    do_start();
    send(8'h03, 0);
    send(d[0], 0);
    do_start();
    check("start_ignored_ready", 32'(in_ready), 32'd1);
    check("start_ignored_write_rst", 32'(write_rst), 32'd0);
    send(d[1], 0);
    send(d[2], 0);
    repeat (2) @(negedge clk);
    check_writes("after_rst", base, expected_writes(d));
    check("after_rst_clr_pulses", 32'(clr_pulses - p0), 32'd1);
    check_flags("after_rst", 1'b1, 1'b0);

    // Full 255-byte image with random source gaps.
    d.delete();
    for (int i = 0; i < 255; i++) d.push_back(8'($urandom));
    run_load("n255", d, 0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
